mdl_bdi_byte_assembler: RTL and testbench
=========================================

// Module: mdl_bdi_byte_assembler
// PURPOSE
//  Consumes the serial bubble data stream (o_MUXED_BDI) from the invalid page data
//  generator. Drops supplementary bits and packs the rest LSB-first into bytes.
//  Keeps an 8-bit page checksum and a page byte count, and queues bytes in a
//  first-word-fall-through (FWFT) FIFO toward the CPU/DMA read side with a valid/ready handshake.
// PARAMETERS
//  PAGE_BYTES  64  data bytes per page; o_PAGE_DONE asserts when this many are assembled
//  FIFO_DEPTH  4   byte FIFO entries; power of 2, >=2
// PORTS
//  i_MCLK           in   1   master clock
//  i_SYS_RST_n      in   1   reset, asynchronous, active-low
//  i_CLK2M_PCEN_n   in   1   bit-side clock enable, active-low
//  i_PAGE_START     in   1   page start strobe, sampled on bit-side enabled edges
//  i_BIT_VALID      in   1   i_MUXED_BDI carries a bit this enabled edge
//  i_SUPBD_ACT_n    in   1   0 = current bit is supplementary: discard it
//  i_MUXED_BDI      in   1   serial data bit (bubble data XOR invalid page pattern)
//  o_BYTE_DATA      out  8   FIFO head byte (FWFT)
//  o_BYTE_VALID     out  1   FIFO not empty
//  i_BYTE_READY     in   1   consumer accepts head byte
//  o_FIFO_LEVEL     out  $clog2(FIFO_DEPTH)+1   bytes held, 0..FIFO_DEPTH
//  o_CHKSUM         out  8   mod-256 sum of bytes assembled this page
//  o_PAGE_DONE      out  1   PAGE_BYTES bytes assembled; level signal
//  o_OVERRUN        out  1   sticky: a byte completed while the FIFO was full
//  o_BUSY           out  1   state == ASSEMBLE
// BEHAVIOUR
//  Clock enable and reset
//   - Bit-side logic (FSM, bit/byte counters, shift register, checksum, push) updates
//     only on i_MCLK rising edges with i_CLK2M_PCEN_n==0.
//   - FIFO pop updates on every i_MCLK edge.
//   - Reset: state IDLE, all counters 0, FIFO empty.
//   - Reset values: o_BYTE_DATA=0, o_BYTE_VALID=0, o_FIFO_LEVEL=0, o_CHKSUM=0,
//     o_PAGE_DONE=0, o_OVERRUN=0, o_BUSY=0.
//   - Reset mid-page discards the partial byte and all FIFO contents.
//  FSM: IDLE, ASSEMBLE, DONE
//   - IDLE -> ASSEMBLE on i_PAGE_START.
//   - ASSEMBLE -> DONE on the enabled edge that completes byte number PAGE_BYTES.
//   - DONE -> ASSEMBLE on i_PAGE_START.
//   - i_PAGE_START in ASSEMBLE restarts the page: partial byte dropped, counters cleared.
//   - On i_PAGE_START the page clears: bit count, byte count, o_CHKSUM, o_PAGE_DONE
//     and o_OVERRUN all go to 0. The FIFO is NOT flushed.
//   - A bit presented on the same edge as i_PAGE_START is ignored.
//  Bit assembly
//   - Accept a bit when state==ASSEMBLE & i_BIT_VALID & i_SUPBD_ACT_n.
//   - Accepted bits shift in LSB-first: the first bit becomes bit 0.
//   - Bits arriving in IDLE or DONE, or with i_SUPBD_ACT_n==0, are ignored.
//   - The 3-bit bit counter wraps 7->0.
//   - When the 8th bit is accepted the byte completes on that same edge:
//     checksum += byte (mod 256), byte count +1, push attempted.
//  FIFO
//   - Push succeeds if not full, or if a pop occurs on the same i_MCLK edge.
//     In the pop case the level is unchanged.
//   - If full with no pop: the byte is dropped, o_OVERRUN is set, and the checksum
//     and byte count still advance.
//   - Pop when o_BYTE_VALID & i_BYTE_READY. i_BYTE_READY with an empty FIFO has no effect.
//   - Latency: the completing edge shows the byte on o_BYTE_DATA with o_BYTE_VALID=1
//     right after that edge, if the FIFO was empty.
//   - o_BYTE_DATA holds its last value when the FIFO is empty.
//   - Read and write pointers wrap modulo FIFO_DEPTH.
// TESTING
//  1 Start; 8 bits 1,0,1,1,0,0,1,0 -> o_BYTE_DATA=0x4D, o_BYTE_VALID=1 one edge after the 8th bit, o_CHKSUM=0x4D.
//  2 Start; 64 bytes 0x00..0x3F, ready=1 -> o_PAGE_DONE=1, o_CHKSUM=0xE0, state DONE; further bits ignored.
//  3 ready=0; 5 bytes (FIFO_DEPTH=4) -> level=4, o_OVERRUN=1, 5th byte lost, checksum includes all 5.
//  4 Full FIFO; 8th bit edge coincides with pop -> level stays 4, o_OVERRUN=0, byte order preserved.
//  5 3 accepted bits, then 4 bits with i_SUPBD_ACT_n=0, then 5 more accepted bits -> one byte from the 8 accepted bits only.
//  6 i_SYS_RST_n pulse mid-byte, or i_PAGE_START after 5 bits -> partial byte discarded; next 8 bits form byte 0, checksum restarts at 0.

Source files
------------

// File: rtl/mdl_bdi_byte_assembler.sv
// mdl_bdi_byte_assembler
// Packs the serial bubble data stream into LSB-first bytes, tracks a per-page
// checksum and byte count, and queues finished bytes in a small FWFT FIFO
// toward the CPU/DMA read side.
module mdl_bdi_byte_assembler #(
    parameter int PAGE_BYTES = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_MCLK,
    input  logic                          i_SYS_RST_n,
    input  logic                          i_CLK2M_PCEN_n,
    input  logic                          i_PAGE_START,
    input  logic                          i_BIT_VALID,
    input  logic                          i_SUPBD_ACT_n,
    input  logic                          i_MUXED_BDI,
    output logic [7:0]                    o_BYTE_DATA,
    output logic                          o_BYTE_VALID,
    input  logic                          i_BYTE_READY,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_LEVEL,
    output logic [7:0]                    o_CHKSUM,
    output logic                          o_PAGE_DONE,
    output logic                          o_OVERRUN,
    output logic                          o_BUSY
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(PAGE_BYTES + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(PAGE_BYTES - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]       chksum_q, chksum_d;
    logic             page_done_q, page_done_d;
    logic             overrun_q, overrun_d;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [7:0]       head_q, head_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic             bit_en;
    logic             start;
    logic             accept;
    logic             byte_done;
    logic             last_byte;
    logic [7:0]       new_byte;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [PW-1:0]    rd_nxt;

    // Bit-side strobes: enable, page start, and the byte being completed
    always_comb begin
        bit_en    = ~i_CLK2M_PCEN_n;
        start     = bit_en & i_PAGE_START;
        new_byte  = {i_MUXED_BDI, shift_q[7:1]};
        byte_done = accept & (bit_cnt_q == 3'd7);
        last_byte = byte_done & (byte_cnt_q == LAST_BYTE);
    end

    // FSM state register
    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) state_q <= ST_IDLE;
        else if (bit_en)  state_q <= state_d;
    end

    // FSM next state: a page start always (re)enters ASSEMBLE
    always_comb begin
        state_d = state_q;
        if (start)
            state_d = ST_ASSEMBLE;
        else if (state_q == ST_ASSEMBLE && last_byte)
            state_d = ST_DONE;
    end

    // FSM outputs: bit acceptance is suppressed on the page-start edge
    always_comb begin
        o_BUSY = (state_q == ST_ASSEMBLE);
        accept = bit_en & ~i_PAGE_START & (state_q == ST_ASSEMBLE)
                 & i_BIT_VALID & i_SUPBD_ACT_n;
    end

    // Page datapath next-state: shift register, counters, checksum, flags
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        chksum_d    = chksum_q;
        page_done_d = page_done_q;
        overrun_d   = overrun_q;
        if (start) begin
            shift_d     = '0;
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
            chksum_d    = '0;
            page_done_d = 1'b0;
            overrun_d   = 1'b0;
        end else if (accept) begin
            // shift right so the first accepted bit ends up in bit 0
            shift_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done) begin
                chksum_d   = chksum_q + new_byte;
                byte_cnt_d = byte_cnt_q + BW'(1);
                if (last_byte)
                    page_done_d = 1'b1;
                // byte lost when the FIFO cannot take it this edge
                if (fifo_full && !pop)
                    overrun_d = 1'b1;
            end
        end
    end

    // Page datapath registers, gated by the bit-side enable
    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            chksum_q    <= '0;
            page_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (bit_en) begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            chksum_q    <= chksum_d;
            page_done_q <= page_done_d;
            overrun_q   <= overrun_d;
        end
    end

    // FIFO control: pop on every clock, push only from a completed byte
    always_comb begin
        fifo_full  = (level_q == FULL_LVL);
        fifo_empty = (level_q == '0);
        pop        = ~fifo_empty & i_BYTE_READY;
        push       = byte_done & (~fifo_full | pop);
        rd_nxt     = rd_ptr_q + PW'(1);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_nxt : rd_ptr_q;
        level_d    = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FWFT head register: holds the last byte once the FIFO drains
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (level_q == LW'(1))
                head_d = push ? new_byte : head_q;
            else
                head_d = mem_q[rd_nxt];
        end else if (push && fifo_empty) begin
            head_d = new_byte;
        end
    end

    // FIFO pointer, level and head registers (every clock edge)
    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    // FIFO storage; contents are don't-care until the level covers them
    always_ff @(posedge i_MCLK) begin
        if (push) mem_q[wr_ptr_q] <= new_byte;
    end

    // Output drive
    always_comb begin
        o_BYTE_DATA  = head_q;
        o_BYTE_VALID = ~fifo_empty;
        o_FIFO_LEVEL = level_q;
        o_CHKSUM     = chksum_q;
        o_PAGE_DONE  = page_done_q;
        o_OVERRUN    = overrun_q;
    end

endmodule

// File: tb/tb_mdl_bdi_byte_assembler.sv
// Directed bench for mdl_bdi_byte_assembler (PAGE_BYTES=64, FIFO_DEPTH=4).
module tb_mdl_bdi_byte_assembler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pcen_n = 1'b0;
    logic       page_start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       supbd_n = 1'b1;
    logic       bdi = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [2:0] level;
    logic [7:0] chksum;
    logic       page_done;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    mdl_bdi_byte_assembler #(.PAGE_BYTES(64), .FIFO_DEPTH(4)) dut (
        .i_MCLK(clk), .i_SYS_RST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n),
        .i_PAGE_START(page_start), .i_BIT_VALID(bit_valid),
        .i_SUPBD_ACT_n(supbd_n), .i_MUXED_BDI(bdi),
        .o_BYTE_DATA(byte_data), .o_BYTE_VALID(byte_valid),
        .i_BYTE_READY(ready), .o_FIFO_LEVEL(level), .o_CHKSUM(chksum),
        .o_PAGE_DONE(page_done), .o_OVERRUN(overrun), .o_BUSY(busy)
    );

    always #5 clk = ~clk;

    // one bit-side edge; inputs change away from the rising edge
    task automatic drive_bit(input logic b, input logic sn, input logic vld, input logic pn);
        @(negedge clk);
        bdi = b; supbd_n = sn; bit_valid = vld; pcen_n = pn;
        @(posedge clk); #1;
        bit_valid = 1'b0; supbd_n = 1'b1; pcen_n = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) drive_bit(v[i], 1'b1, 1'b1, 1'b0);
    endtask

    // page start with a valid bit on the same edge (that bit must be ignored)
    task automatic start_page();
        @(negedge clk);
        page_start = 1'b1; bit_valid = 1'b1; bdi = 1'b1;
        @(posedge clk); #1;
        page_start = 1'b0; bit_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] exp, input string nm);
        if (byte_valid !== 1'b1 || byte_data !== exp) begin
            n_bad++;
            $display("FAIL %s: valid=%b data=%h, want valid=1 data=%h", nm, byte_valid, byte_data, exp);
        end
        n_cmp++;
        @(negedge clk); ready = 1'b1;
        @(posedge clk); #1; ready = 1'b0;
    endtask

    task automatic test_reset();
        if ({byte_data, byte_valid, level, chksum, page_done, overrun, busy} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset: data=%h v=%b lvl=%0d ck=%h pd=%b ov=%b busy=%b, want all 0",
                     byte_data, byte_valid, level, chksum, page_done, overrun, busy);
        end
        n_cmp++;
    endtask

    task automatic test_first_byte();
        logic [7:0] bits;
        start_page();
        if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: %b want 1", busy); end
        n_cmp++;
        bits = 8'b0100_1101; // sent 1,0,1,1,0,0,1,0
        for (int i = 0; i < 7; i++) drive_bit(bits[i], 1'b1, 1'b1, 1'b0);
        if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL early_valid: %b want 0", byte_valid); end
        n_cmp++;
        drive_bit(bits[7], 1'b1, 1'b1, 1'b0);
        if (byte_valid !== 1'b1 || byte_data !== 8'h4D || chksum !== 8'h4D || level !== 3'd1) begin
            n_bad++;
            $display("FAIL first_byte: v=%b data=%h ck=%h lvl=%0d, want 1 4d 4d 1",
                     byte_valid, byte_data, chksum, level);
        end
        n_cmp++;
        pop_expect(8'h4D, "first_pop");
        if (byte_valid !== 1'b0 || level !== 3'd0 || byte_data !== 8'h4D) begin
            n_bad++;
            $display("FAIL empty_hold: v=%b lvl=%0d data=%h, want 0 0 4d", byte_valid, level, byte_data);
        end
        n_cmp++;
    endtask

    task automatic test_full_page();
        start_page();
        ready = 1'b1;
        for (int i = 0; i < 63; i++) send_byte(8'(i));
        if (page_done !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL page_63: pd=%b busy=%b, want 0 1", page_done, busy);
        end
        n_cmp++;
        send_byte(8'h3F);
        if (page_done !== 1'b1 || chksum !== 8'hE0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL page_64: pd=%b ck=%h busy=%b, want 1 e0 0", page_done, chksum, busy);
        end
        n_cmp++;
        send_byte(8'hFF);
        if (level !== 3'd0 || chksum !== 8'hE0 || page_done !== 1'b1 || byte_data !== 8'h3F) begin
            n_bad++;
            $display("FAIL done_ignore: lvl=%0d ck=%h pd=%b data=%h, want 0 e0 1 3f",
                     level, chksum, page_done, byte_data);
        end
        n_cmp++;
        ready = 1'b0;
    endtask

    task automatic test_overrun();
        start_page();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        if (level !== 3'd4 || overrun !== 1'b0) begin
            n_bad++; $display("FAIL fill4: lvl=%0d ov=%b, want 4 0", level, overrun);
        end
        n_cmp++;
        send_byte(8'h55);
        if (level !== 3'd4 || overrun !== 1'b1 || chksum !== 8'hFF) begin
            n_bad++; $display("FAIL overrun: lvl=%0d ov=%b ck=%h, want 4 1 ff", level, overrun, chksum);
        end
        n_cmp++;
        pop_expect(8'h11, "ovr_d0"); pop_expect(8'h22, "ovr_d1");
        pop_expect(8'h33, "ovr_d2"); pop_expect(8'h44, "ovr_d3");
        if (byte_valid !== 1'b0 || overrun !== 1'b1) begin
            n_bad++; $display("FAIL ovr_lost: v=%b ov=%b, want 0 1", byte_valid, overrun);
        end
        n_cmp++;
        start_page();
        if (overrun !== 1'b0 || chksum !== 8'h00) begin
            n_bad++; $display("FAIL start_clear: ov=%b ck=%h, want 0 00", overrun, chksum);
        end
        n_cmp++;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] v;
        start_page();
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        v = 8'hA5;
        for (int i = 0; i < 7; i++) drive_bit(v[i], 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bdi = v[7]; bit_valid = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0; ready = 1'b0;
        if (level !== 3'd4 || overrun !== 1'b0 || byte_data !== 8'hA2) begin
            n_bad++; $display("FAIL push_pop_full: lvl=%0d ov=%b data=%h, want 4 0 a2", level, overrun, byte_data);
        end
        n_cmp++;
        pop_expect(8'hA2, "pp_d0"); pop_expect(8'hA3, "pp_d1");
        pop_expect(8'hA4, "pp_d2"); pop_expect(8'hA5, "pp_d3");
        if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL pp_empty: v=%b want 0", byte_valid); end
        n_cmp++;
    endtask

    task automatic test_supbd();
        start_page();
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b1, 1'b0); // supplementary
        drive_bit(1'b1, 1'b1, 1'b1, 1'b1); // clock enable off
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0); // no valid bit
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        if (level !== 3'd0) begin n_bad++; $display("FAIL supbd_7: lvl=%0d want 0", level); end
        n_cmp++;
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
        if (level !== 3'd1 || byte_data !== 8'h4B || chksum !== 8'h4B) begin
            n_bad++; $display("FAIL supbd: lvl=%0d data=%h ck=%h, want 1 4b 4b", level, byte_data, chksum);
        end
        n_cmp++;
        pop_expect(8'h4B, "supbd_pop");
    endtask

    task automatic test_restart();
        start_page();
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        start_page();
        send_byte(8'h3C);
        if (level !== 3'd1 || byte_data !== 8'h3C || chksum !== 8'h3C) begin
            n_bad++; $display("FAIL restart: lvl=%0d data=%h ck=%h, want 1 3c 3c", level, byte_data, chksum);
        end
        n_cmp++;
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        if ({byte_data, byte_valid, level, chksum, page_done, overrun, busy} !== 16'h0) begin
            n_bad++;
            $display("FAIL mid_reset: data=%h v=%b lvl=%0d ck=%h busy=%b, want all 0",
                     byte_data, byte_valid, level, chksum, busy);
        end
        n_cmp++;
        @(negedge clk); rst_n = 1'b1;
        send_byte(8'hFF); // IDLE: ignored
        if (level !== 3'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_ignore: lvl=%0d busy=%b, want 0 0", level, busy);
        end
        n_cmp++;
        start_page();
        send_byte(8'h5A);
        if (level !== 3'd1 || byte_data !== 8'h5A || chksum !== 8'h5A || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset: lvl=%0d data=%h ck=%h busy=%b, want 1 5a 5a 1",
                     level, byte_data, chksum, busy);
        end
        n_cmp++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_first_byte();
        test_full_page();
        test_overrun();
        test_push_pop_full();
        test_supbd();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
